// File: rtl/fwd_hazard_tracker.sv
// fwd_hazard_tracker: shadow-pipeline forwarding select precompute and load-use stall detection.
// Optional stall counter output stall_cnt_o enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_tracker #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    input  logic [ADDR_W-1:0]         issue_rd_addr_i,
    input  logic                      issue_reg_write_i,
    input  logic                      issue_is_load_i,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
    input  logic [NUM_SRC-1:0]        src_used_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic                      ex_valid_o,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt_o
`endif
);
    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic              wr;
        logic              ld;
    } entry_t;

    entry_t                     e [DEPTH];
    logic [NUM_SRC*SEL_W-1:0]   cand;
    logic [NUM_SRC-1:0]         hz;
    logic                       accept;

    // Scan farthest to nearest so the nearest producer overwrites any older match.
    always_comb begin
        cand = '0;
        hz   = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = DEPTH-2; k >= 0; k--) begin
                if (src_used_i[j] && src_addr_i[j*ADDR_W +: ADDR_W] != '0 && e[k].v && e[k].wr &&
                    e[k].rd != '0 && e[k].rd == src_addr_i[j*ADDR_W +: ADDR_W]) begin
                    cand[j*SEL_W +: SEL_W] = SEL_W'(k+1);
                    hz[j] = e[k].ld && ((k+1) <= LOAD_LAT);
                end
            end
        end
    end

    assign stall_o = issue_valid_i && !flush_i && |hz;
    assign accept  = issue_valid_i && !flush_i && !(|hz);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < DEPTH; k++) e[k] <= '0;
            ex_valid_o <= 1'b0;
            fwd_sel_o  <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) e[k] <= e[k-1];
            e[0]       <= accept ? {1'b1, issue_rd_addr_i, issue_reg_write_i, issue_is_load_i} : '0;
            ex_valid_o <= accept;
            fwd_sel_o  <= accept ? cand : '0;
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_o <= '0;
        else if (stall_o && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif
endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
- Parametrised successor to the EX-stage forwarding logic.
- Tracks in-flight destination registers in an internal shadow pipeline of DEPTH stages (stage 0 = EX).
- Precomputes per-operand forwarding selects for the instruction in ID, registered so they are valid when that instruction is in EX.
- Detects load-use hazards and emits a stall. Supports NUM_SRC source operands, configurable depth and load latency.

Parameters:
ADDR_W, 5, register address width; address 0 is the hard-wired zero register.
NUM_SRC, 2, source operands per instruction.
DEPTH, 3, tracked stages after ID (0=EX, 1=MEM, 2=WB); legal range 2..8.
LOAD_LAT, 1, load data forwardable only from stage index > LOAD_LAT; legal range 0..DEPTH-2.
SEL_W, $clog2(DEPTH), derived, width of one forwarding select.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
issue_valid_i  in  1  instruction in ID requests to advance into EX.
issue_rd_addr_i  in  ADDR_W  destination of the ID instruction.
issue_reg_write_i  in  1  ID instruction writes the register file.
issue_is_load_i  in  1  ID instruction is a load.
src_addr_i  in  NUM_SRC*ADDR_W  source addresses of the ID instruction; operand j at bits [j*ADDR_W +: ADDR_W].
src_used_i  in  NUM_SRC  per-operand "source is read" mask.
flush_i  in  1  kill the ID instruction this cycle.
stall_o  out  1  combinational: hold PC/IF/ID this cycle.
ex_valid_o  out  1  registered: EX holds a real instruction.
fwd_sel_o  out  NUM_SRC*SEL_W  registered: per-operand select for EX. 0 = register file; k = forward from stage k.

Behaviour:
- Entry e[k], k=0..DEPTH-1, fields: {v, rd, wr, ld}. Entry "live" = v && wr && rd!=0.
- Match, per operand j: src_used_i[j], src!=0, and live e[k] with e[k].rd==src, for k in 0..DEPTH-2.
  - Nearest match (smallest k) wins.
  - Candidate select c_j = k+1, i.e. the producer's stage when the consumer reaches EX. No match -> c_j = 0.
- Hazard: exists j whose nearest match is at k with e[k].ld and k+1 <= LOAD_LAT.
- stall_o = issue_valid_i && !flush_i && hazard. Purely combinational, no added latency.
- accept = issue_valid_i && !flush_i && !stall_o.
- Every rising edge:
  - e[k] <= e[k-1] for k>=1. Downstream never stalls.
  - If accept: e[0] <= {1, issue_rd_addr_i, issue_reg_write_i, issue_is_load_i}, ex_valid_o <= 1, fwd_sel_o <= {c_j}.
  - Otherwise a bubble: e[0] <= 0, ex_valid_o <= 0, fwd_sel_o <= 0.
- flush_i has priority over a hazard: no stall, bubble inserted.
- Stalled ID instruction re-evaluates next cycle against the shifted entries. Default config gives exactly one stall cycle, then select 2.
- issue_valid_i low: stall_o=0, bubble inserted.
- Both operands may match different stages independently. Both matching the same entry gives the same select.
- Reset (async, rst_i=0): all e[k] cleared, ex_valid_o=0, fwd_sel_o=0, stall_o=0 (no live entries). Reset mid-operation discards all in-flight state immediately.
- Release of reset is synchronised externally. The first edge after release behaves normally.

Optional Feature:
Macro FWD_STALL_CNT_EN.
- Defined: adds output stall_cnt_o (16 bits).
  - Increments on every clock edge where stall_o=1.
  - Saturates at 16'hFFFF; cleared by reset.
  - Flushed cycles do not count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Back-to-back ALU RAW, defaults: issue rd=3 wr=1, next cycle issue src0=3 -> stall_o=0; next edge fwd_sel_o[1:0]=1.
- Two-apart RAW: issue rd=4, unrelated instr, then src1=4 -> fwd_sel_o[3:2]=2. Same case with rd=4 in e[0] and e[1] -> nearest wins, select=1.
- Load-use: issue ld rd=5, next cycle src0=5 -> stall_o=1 for exactly 1 cycle, ex_valid_o=0 after that edge; next cycle stall_o=0, then fwd_sel_o[1:0]=2.
- Zero/unused: producer rd=0 wr=1, consumer src0=0 -> select 0. Producer rd=7 wr=0 -> select 0. src_used_i[0]=0 with a matching address -> select 0, no stall.
- Flush vs hazard: load-use condition with flush_i=1 -> stall_o=0, bubble, fwd_sel_o=0. rst_i pulled low mid-stream -> ex_valid_o=0 and fwd_sel_o=0 immediately, with no clock edge.
- With FWD_STALL_CNT_EN: 3 separate load-use events -> stall_cnt_o=3; preload near 16'hFFFF and stall -> holds at 16'hFFFF.
